// File: rtl/sorter_pkg.sv
// ============================================================================
// Module  : sorter_pkg
// Purpose : Shared helpers and lane-slicing macros for the pipelined sorter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef SORTER_PKG_MACROS
`define SORTER_PKG_MACROS
`define SORTER_KEY(vec, k) vec[DW*(k) +: DW]
`define SORTER_IDX(vec, k) vec[IDXW*(k) +: IDXW]
`endif

package sorter_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Even stages pair (0,1),(2,3)...; odd stages pair (1,2),(3,4)...
  function automatic int stage_parity(input int stage);
    return stage % 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sort_cmp_swap.sv
// ============================================================================
// Module  : sort_cmp_swap
// Purpose : Combinational compare-exchange of a {key,tag} pair, asc or desc.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sort_cmp_swap #(
  parameter int DW   = 8,
  parameter int IDXW = 2
) (
  input  logic            i_desc,
  input  logic [DW-1:0]   i_key_a,
  input  logic [IDXW-1:0] i_idx_a,
  input  logic [DW-1:0]   i_key_b,
  input  logic [IDXW-1:0] i_idx_b,
  output logic [DW-1:0]   o_key_a,
  output logic [IDXW-1:0] o_idx_a,
  output logic [DW-1:0]   o_key_b,
  output logic [IDXW-1:0] o_idx_b
);

  logic w_swap;

  // Strict comparison keeps equal keys in place, which makes the network stable.
  assign w_swap  = i_desc ? (i_key_a < i_key_b) : (i_key_a > i_key_b);

  assign o_key_a = w_swap ? i_key_b : i_key_a;
  assign o_idx_a = w_swap ? i_idx_b : i_idx_a;
  assign o_key_b = w_swap ? i_key_a : i_key_b;
  assign o_idx_b = w_swap ? i_idx_a : i_idx_b;

endmodule

`default_nettype wire

// File: rtl/pipelined_sorter.sv
// ============================================================================
// Module  : pipelined_sorter
// Purpose : N-stage odd-even transposition sorter with valid/ready and tags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_sorter
  import sorter_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int DW   = 8,
  localparam int IDXW = clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_desc,
  input  logic [DW*N-1:0]    inp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW*N-1:0]    outp,
  output logic [IDXW*N-1:0]  out_idx
);

  logic              r_valid [N];
  logic              r_desc  [N-1];  // the last stage never needs the mode bit again
  logic [DW*N-1:0]   r_keys  [N];
  logic [IDXW*N-1:0] r_tags  [N];

  logic              w_adv;
  logic [IDXW*N-1:0] w_init_tags;
  logic              w_src_valid [N];
  logic              w_src_desc  [N];
  logic [DW*N-1:0]   w_src_keys  [N];
  logic [DW*N-1:0]   w_nxt_keys  [N];
  logic [IDXW*N-1:0] w_src_tags  [N];
  logic [IDXW*N-1:0] w_nxt_tags  [N];

  assign w_adv     = !r_valid[N-1] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_valid[N-1];
  assign outp      = r_keys[N-1];
  assign out_idx   = r_tags[N-1];

  for (genvar k = 0; k < N; k++) begin : g_init_tag
    assign `SORTER_IDX(w_init_tags, k) = IDXW'(k);
  end

  for (genvar s = 0; s < N; s++) begin : g_stage
    localparam int P = stage_parity(s);

    if (s == 0) begin : g_head
      assign w_src_valid[s] = in_valid;
      assign w_src_desc[s]  = in_desc;
      assign w_src_keys[s]  = inp;
      assign w_src_tags[s]  = w_init_tags;
    end else begin : g_body
      assign w_src_valid[s] = r_valid[s-1];
      assign w_src_desc[s]  = r_desc[s-1];
      assign w_src_keys[s]  = r_keys[s-1];
      assign w_src_tags[s]  = r_tags[s-1];
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
      if (k >= P && (k - P) % 2 == 0 && k + 1 < N) begin : g_pair
        sort_cmp_swap #(
          .DW   (DW),
          .IDXW (IDXW)
        ) u_cmp (
          .i_desc  (w_src_desc[s]),
          .i_key_a (`SORTER_KEY(w_src_keys[s], k)),
          .i_idx_a (`SORTER_IDX(w_src_tags[s], k)),
          .i_key_b (`SORTER_KEY(w_src_keys[s], k + 1)),
          .i_idx_b (`SORTER_IDX(w_src_tags[s], k + 1)),
          .o_key_a (`SORTER_KEY(w_nxt_keys[s], k)),
          .o_idx_a (`SORTER_IDX(w_nxt_tags[s], k)),
          .o_key_b (`SORTER_KEY(w_nxt_keys[s], k + 1)),
          .o_idx_b (`SORTER_IDX(w_nxt_tags[s], k + 1))
        );
      end else if (!(k > P && (k - P) % 2 == 1)) begin : g_pass
        assign `SORTER_KEY(w_nxt_keys[s], k) = `SORTER_KEY(w_src_keys[s], k);
        assign `SORTER_IDX(w_nxt_tags[s], k) = `SORTER_IDX(w_src_tags[s], k);
      end
    end
  end

  // Whole pipe moves in lockstep; bubbles occupy a slot like real vectors.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < N; s++) begin
        r_valid[s] <= 1'b0;
        r_keys[s]  <= '0;
        r_tags[s]  <= '0;
      end
      for (int s = 0; s < N - 1; s++) begin
        r_desc[s] <= 1'b0;
      end
    end else if (w_adv) begin
      for (int s = 0; s < N; s++) begin
        r_valid[s] <= w_src_valid[s];
        r_keys[s]  <= w_nxt_keys[s];
        r_tags[s]  <= w_nxt_tags[s];
      end
      for (int s = 0; s < N - 1; s++) begin
        r_desc[s] <= w_src_desc[s];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipelined_sorter.sv
// ============================================================================
// Module  : tb_pipelined_sorter
// Purpose : Self-checking bench for pipelined_sorter (N=4, DW=8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_sorter;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int IDXW = 2;

  typedef struct {
    logic [DW*N-1:0]   k;
    logic [IDXW*N-1:0] t;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_desc;
  logic [DW*N-1:0]   inp;
  logic              out_valid;
  logic              out_ready;
  logic [DW*N-1:0]   outp;
  logic [IDXW*N-1:0] out_idx;

  int   n_tests;
  int   n_fail;
  int   n_out;
  int   cyc;
  exp_t exp_q[$];

  pipelined_sorter #(
    .N  (N),
    .DW (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_desc   (in_desc),
    .inp       (inp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outp      (outp),
    .out_idx   (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: stable insertion sort with per-vector direction.
  function automatic exp_t ref_sort(input logic [DW*N-1:0] v, input logic d);
    int   key[N];
    int   tag[N];
    int   tmp;
    exp_t e;
    for (int k = 0; k < N; k++) begin
      key[k] = int'(v[DW*k +: DW]);
      tag[k] = k;
    end
    for (int i = 1; i < N; i++) begin
      for (int j = i; j > 0; j--) begin
        if (d ? (key[j] > key[j-1]) : (key[j] < key[j-1])) begin
          tmp = key[j]; key[j] = key[j-1]; key[j-1] = tmp;
          tmp = tag[j]; tag[j] = tag[j-1]; tag[j-1] = tmp;
        end else begin
          break;
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      e.k[DW*k +: DW]     = key[k][DW-1:0];
      e.t[IDXW*k +: IDXW] = tag[k][IDXW-1:0];
    end
    return e;
  endfunction

  // Scoreboard: sampled mid-cycle, so handshakes seen here complete at the next edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'(out_valid), 64'(0));
        end else begin
          chk("sb_keys", 64'(outp), 64'(exp_q[0].k));
          chk("sb_idx", 64'(out_idx), 64'(exp_q[0].t));
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_sort(inp, in_desc));
    end
  end

  task automatic send(input logic [DW*N-1:0] v, input logic d);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    inp      = v;
    in_desc  = d;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_accepted", 64'(ok), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [DW*N-1:0] k, input logic [IDXW*N-1:0] t);
    for (int w = 0; w < 20 && !out_valid; w++) begin
      @(posedge clk); #1;
    end
    chk({name, "_valid"}, 64'(out_valid), 64'(1));
    chk({name, "_keys"}, 64'(outp), 64'(k));
    chk({name, "_idx"}, 64'(out_idx), 64'(t));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int w = 0; w < 200 && exp_q.size() != 0; w++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int o0;
    int c0;
    logic [DW*N-1:0] v;
    n_tests   = 0;
    n_fail    = 0;
    n_out     = 0;
    cyc       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_desc   = 1'b0;
    inp       = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_outp", 64'(outp), 64'(0));
    chk("reset_out_idx", 64'(out_idx), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));

    // Ascending {3,1,4,2}: visible N-1 edges after the accepting edge
    in_valid = 1'b1; inp = 32'h02040103; in_desc = 1'b0;
    @(negedge clk);
    chk("t1_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("t1_latency_edges", 64'(lat), 64'(N - 1));
    chk("t1_keys", 64'(outp), 64'(32'h04030201));
    chk("t1_idx", 64'(out_idx), 64'({2'd2, 2'd0, 2'd3, 2'd1}));
    @(posedge clk); #1;
    drain();

    // Descending {3,1,4,2}
    send(32'h02040103, 1'b1);
    expect_out("t2", 32'h01020304, {2'd1, 2'd3, 2'd0, 2'd2});
    drain();

    // Stability on {5,5,1,5}, both directions back-to-back
    send(32'h05010505, 1'b0);
    send(32'h05010505, 1'b1);
    expect_out("t3a", 32'h05050501, {2'd3, 2'd1, 2'd0, 2'd2});
    expect_out("t3d", 32'h01050505, {2'd2, 2'd3, 2'd1, 2'd0});
    drain();

    // Backpressure: 6 back-to-back vectors, consumer stalls 10 cycles
    o0 = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          v = {8'(i * 3 + 1), 8'(200 - i), 8'(i), 8'(i * 7 + 5)};
          send(v, 1'(i % 2));
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t4_stall_out_valid", 64'(out_valid), 64'(1));
        chk("t4_stall_in_ready", 64'(in_ready), 64'(0));
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("t4_count", 64'(n_out - o0), 64'(6));

    // Alternating direction at full rate
    o0 = n_out;
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      v = {8'(i * 31), 8'(90 - i), 8'(i * 13 + 7), 8'(45)};
      send(v, 1'(i % 2));
    end
    chk("t5_input_cycles", 64'(cyc - c0), 64'(8));
    repeat (4) @(posedge clk);
    #1;
    chk("t5_output_count", 64'(n_out - o0), 64'(8));
    drain();

    // Reset mid-flight: 3 accepted, reset before the first emerges
    send(32'h0A0B0C0D, 1'b0);
    send(32'h11223344, 1'b1);
    send(32'h09080706, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_out_valid", 64'(out_valid), 64'(0));
    chk("t6_outp", 64'(outp), 64'(0));
    chk("t6_out_idx", 64'(out_idx), 64'(0));
    chk("t6_in_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("t6_quiet", 64'(out_valid), 64'(0));
    end
    send(32'h01020304, 1'b0);
    expect_out("t6_after", 32'h04030201, {2'd0, 2'd1, 2'd2, 2'd3});
    drain();

    // Random traffic with frequent ties
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_desc   = ($urandom_range(0, 1) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) inp[DW*k +: DW] = 8'($urandom_range(0, 5));
      @(posedge clk); #1;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
